// File: rtl/core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_pkg: shared widths and helpers for the decode stage             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package core_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = 5;
  localparam int IMM_W  = 12;

  function automatic logic [XLEN-1:0] sign_extend_imm(input logic [IMM_W-1:0] imm);
    return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_regfile_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | decode_regfile_if: fetch, execute and write-back signals of decode   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface decode_regfile_if;
  import core_pkg::*;

  logic                id_valid;
  logic                id_ready;
  logic [REG_AW-1:0]   rd;
  logic [REG_AW-1:0]   rs1;
  logic [REG_AW-1:0]   rs2;
  logic [IMM_W-1:0]    imm;
  logic                id_wen;

  logic                ex_valid;
  logic                ex_ready;
  logic [XLEN-1:0]     ex_rs1_data;
  logic [XLEN-1:0]     ex_rs2_data;
  logic [XLEN-1:0]     ex_imm;
  logic [REG_AW-1:0]   ex_rd;
  logic                ex_wen;

  logic                wb_en;
  logic [REG_AW-1:0]   wb_addr;
  logic [XLEN-1:0]     wb_data;

  modport master (
    output id_valid, rd, rs1, rs2, imm, id_wen, ex_ready, wb_en, wb_addr, wb_data,
    input  id_ready, ex_valid, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd, ex_wen
  );

  modport slave (
    input  id_valid, rd, rs1, rs2, imm, id_wen, ex_ready, wb_en, wb_addr, wb_data,
    output id_ready, ex_valid, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd, ex_wen
  );

endinterface
`default_nettype wire

// File: rtl/regfile_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_array: 2R1W register storage, x0 hardwired, write bypass     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module regfile_array
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [REG_AW-1:0] raddr1_i,
  output logic [XLEN-1:0]   rdata1_o,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [XLEN-1:0]   rdata2_o
);

  logic [XLEN-1:0] mem_q [NREGS];
  logic            wr;

  assign wr = we_i && (waddr_i != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // A same-cycle write is forwarded so a stalled reader can issue on the write-back edge
  assign rdata1_o = (raddr1_i == '0)              ? '0      :
                    (wr && (waddr_i == raddr1_i)) ? wdata_i : mem_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0)              ? '0      :
                    (wr && (waddr_i == raddr2_i)) ? wdata_i : mem_q[raddr2_i];

endmodule
`default_nettype wire

// File: rtl/decode_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | decode_regfile: operand read, write-back scoreboard, EX pipe register|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module decode_regfile
  import core_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  decode_regfile_if.slave bus
);

  logic [NREGS-1:0]  pending_q, pending_d;
  logic              ex_valid_q, ex_valid_d;
  logic [XLEN-1:0]   ex_rs1_q, ex_rs1_d;
  logic [XLEN-1:0]   ex_rs2_q, ex_rs2_d;
  logic [XLEN-1:0]   ex_imm_q, ex_imm_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic              ex_wen_q, ex_wen_d;

  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic              wb_write;
  logic              rs1_busy, rs2_busy, rd_busy;
  logic              hazard, slot_free, id_ready, accept;

  regfile_array u_regs (
    .clk      (clk),
    .rst      (rst),
    .we_i     (bus.wb_en),
    .waddr_i  (bus.wb_addr),
    .wdata_i  (bus.wb_data),
    .raddr1_i (bus.rs1),
    .rdata1_o (rs1_data),
    .raddr2_i (bus.rs2),
    .rdata2_o (rs2_data)
  );

  assign wb_write = bus.wb_en && (bus.wb_addr != '0);

  // A pending bit being cleared this cycle no longer blocks its readers
  assign rs1_busy = pending_q[bus.rs1] && !(wb_write && (bus.wb_addr == bus.rs1));
  assign rs2_busy = pending_q[bus.rs2] && !(wb_write && (bus.wb_addr == bus.rs2));
  assign rd_busy  = pending_q[bus.rd]  && !(wb_write && (bus.wb_addr == bus.rd));

  assign hazard    = rs1_busy || rs2_busy || (bus.id_wen && (bus.rd != '0) && rd_busy);
  assign slot_free = !ex_valid_q || bus.ex_ready;
  assign id_ready  = !rst || (!hazard && slot_free);
  assign accept    = rst && bus.id_valid && id_ready;

  always_comb begin
    pending_d  = pending_q;
    ex_valid_d = ex_valid_q;
    ex_rs1_d   = ex_rs1_q;
    ex_rs2_d   = ex_rs2_q;
    ex_imm_d   = ex_imm_q;
    ex_rd_d    = ex_rd_q;
    ex_wen_d   = ex_wen_q;

    // Clear before set so a new writer of the same register keeps it pending
    if (wb_write) begin
      pending_d[bus.wb_addr] = 1'b0;
    end
    if (accept && bus.id_wen && (bus.rd != '0)) begin
      pending_d[bus.rd] = 1'b1;
    end
    pending_d[0] = 1'b0;

    if (accept) begin
      ex_valid_d = 1'b1;
      ex_rs1_d   = rs1_data;
      ex_rs2_d   = rs2_data;
      ex_imm_d   = sign_extend_imm(bus.imm);
      ex_rd_d    = bus.rd;
      ex_wen_d   = bus.id_wen;
    end else if (ex_valid_q && bus.ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_q  <= '0;
      ex_valid_q <= 1'b0;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      ex_imm_q   <= '0;
      ex_rd_q    <= '0;
      ex_wen_q   <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      ex_valid_q <= ex_valid_d;
      ex_rs1_q   <= ex_rs1_d;
      ex_rs2_q   <= ex_rs2_d;
      ex_imm_q   <= ex_imm_d;
      ex_rd_q    <= ex_rd_d;
      ex_wen_q   <= ex_wen_d;
    end
  end

  assign bus.id_ready    = id_ready;
  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_rs1_data = ex_rs1_q;
  assign bus.ex_rs2_data = ex_rs2_q;
  assign bus.ex_imm      = ex_imm_q;
  assign bus.ex_rd       = ex_rd_q;
  assign bus.ex_wen      = ex_wen_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_decode_regfile: scoreboard bench for decode_regfile               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_decode_regfile;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        wen;
  } exp_t;

  logic clk;
  logic rst;
  decode_regfile_if bus ();

  decode_regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_err;
  logic [31:0] mreg [32];
  logic [31:0] mpend;
  logic        mexv;
  exp_t        exp_cur;
  exp_t        sb [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic m_busy(input logic [4:0] r);
    return mpend[r] && !(bus.wb_en && bus.wb_addr != 5'd0 && bus.wb_addr == r);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (bus.wb_en && bus.wb_addr == r) return bus.wb_data;
    return mreg[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    mpend   = 32'd0;
    mexv    = 1'b0;
    exp_cur = '0;
    sb.delete();
  endtask

  task automatic run_cycle();
    logic exp_rdy;
    logic acc;
    exp_t e;
    @(negedge clk);
    if (!rst) exp_rdy = 1'b1;
    else exp_rdy = !(m_busy(bus.rs1) || m_busy(bus.rs2) ||
                     (bus.id_wen && bus.rd != 5'd0 && m_busy(bus.rd))) &&
                   (!mexv || bus.ex_ready);
    check_eq("id_ready", {31'd0, bus.id_ready}, {31'd0, exp_rdy});
    acc = rst && bus.id_valid && exp_rdy;
    if (acc) begin
      e.a   = m_read(bus.rs1);
      e.b   = m_read(bus.rs2);
      e.imm = {{20{bus.imm[11]}}, bus.imm};
      e.rd  = bus.rd;
      e.wen = bus.id_wen;
      sb.push_back(e);
    end
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      if (bus.wb_en && bus.wb_addr != 5'd0) begin
        mreg[bus.wb_addr]  = bus.wb_data;
        mpend[bus.wb_addr] = 1'b0;
      end
      if (acc && bus.id_wen && bus.rd != 5'd0) mpend[bus.rd] = 1'b1;
      if (acc) begin
        exp_cur = sb.pop_front();
        mexv    = 1'b1;
      end else if (mexv && bus.ex_ready) begin
        mexv = 1'b0;
      end
    end
    #1;
    check_eq("ex_valid", {31'd0, bus.ex_valid}, {31'd0, mexv});
    check_eq("ex_rs1_data", bus.ex_rs1_data, exp_cur.a);
    check_eq("ex_rs2_data", bus.ex_rs2_data, exp_cur.b);
    check_eq("ex_imm", bus.ex_imm, exp_cur.imm);
    check_eq("ex_rd", {27'd0, bus.ex_rd}, {27'd0, exp_cur.rd});
    check_eq("ex_wen", {31'd0, bus.ex_wen}, {31'd0, exp_cur.wen});
  endtask

  task automatic cyc(input logic v, input logic [4:0] rd_, input logic [4:0] rs1_,
                     input logic [4:0] rs2_, input logic [11:0] im, input logic wen,
                     input logic exr, input logic wbe, input logic [4:0] wba,
                     input logic [31:0] wbd);
    bus.id_valid = v;
    bus.rd       = rd_;
    bus.rs1      = rs1_;
    bus.rs2      = rs2_;
    bus.imm      = im;
    bus.id_wen   = wen;
    bus.ex_ready = exr;
    bus.wb_en    = wbe;
    bus.wb_addr  = wba;
    bus.wb_data  = wbd;
    run_cycle();
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    model_reset();
    rst = 1'b0;
    cyc(1, 5'd1, 5'd2, 5'd3, 12'h7FF, 1, 1, 1, 5'd4, 32'hDEAD_BEEF);

    // reset held with a valid instruction and write-back present
    cyc(1, 5'd1, 5'd2, 5'd3, 12'h7FF, 1, 1, 1, 5'd4, 32'hDEAD_BEEF);
    check_eq("reset_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    rst = 1'b1;

    // every register reads 0 after reset
    for (int i = 1; i < 32; i++) begin
      cyc(1, 5'd0, 5'(i), 5'(31 - i + 1), 12'h000, 0, 1, 0, 5'd0, 32'd0);
    end
    cyc(0, 5'd0, 5'd0, 5'd0, 12'h000, 0, 1, 0, 5'd0, 32'd0);

    // back-to-back with sign-extended immediate
    cyc(0, 5'd0, 5'd0, 5'd0, 12'h000, 0, 1, 1, 5'd3, 32'h0000_1234);
    cyc(1, 5'd0, 5'd3, 5'd0, 12'hFFF, 0, 1, 0, 5'd0, 32'd0);
    check_eq("b2b_rs1", bus.ex_rs1_data, 32'h0000_1234);
    check_eq("b2b_imm", bus.ex_imm, 32'hFFFF_FFFF);
    cyc(1, 5'd0, 5'd3, 5'd3, 12'h123, 0, 1, 0, 5'd0, 32'd0);

    // RAW stall released by write-back with bypassed data
    cyc(1, 5'd5, 5'd0, 5'd0, 12'h001, 1, 1, 0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) cyc(1, 5'd0, 5'd5, 5'd0, 12'h002, 0, 1, 0, 5'd0, 32'd0);
    check_eq("raw_stalled", {31'd0, bus.id_ready}, 32'd0);
    cyc(1, 5'd0, 5'd5, 5'd0, 12'h002, 0, 1, 1, 5'd5, 32'h0000_ABCD);
    check_eq("raw_bypass", bus.ex_rs1_data, 32'h0000_ABCD);

    // x0 writer never stalls; x0 write ignored
    cyc(1, 5'd0, 5'd0, 5'd0, 12'h003, 1, 1, 0, 5'd0, 32'd0);
    cyc(1, 5'd0, 5'd0, 5'd0, 12'h004, 0, 1, 1, 5'd0, 32'h0000_FFFF);
    cyc(1, 5'd0, 5'd0, 5'd0, 12'h005, 0, 1, 0, 5'd0, 32'd0);
    check_eq("x0_read", bus.ex_rs1_data, 32'd0);

    // backpressure holds the EX register, then loads on release
    cyc(1, 5'd9, 5'd3, 5'd5, 12'h800, 1, 1, 0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) cyc(1, 5'd10, 5'd3, 5'd0, 12'h00A, 1, 0, 0, 5'd0, 32'd0);
    cyc(1, 5'd10, 5'd3, 5'd0, 12'h00A, 1, 1, 0, 5'd0, 32'd0);
    check_eq("bp_new_rd", {27'd0, bus.ex_rd}, 32'd10);

    // set/clear collision on x7 keeps it pending
    cyc(1, 5'd7, 5'd0, 5'd0, 12'h000, 1, 1, 0, 5'd0, 32'd0);
    cyc(1, 5'd7, 5'd0, 5'd0, 12'h000, 1, 1, 1, 5'd7, 32'h7777_0000);
    cyc(1, 5'd0, 5'd7, 5'd0, 12'h000, 0, 1, 0, 5'd0, 32'd0);
    check_eq("collide_stall", {31'd0, bus.id_ready}, 32'd0);
    cyc(1, 5'd0, 5'd7, 5'd0, 12'h000, 0, 1, 1, 5'd7, 32'h7777_0001);

    // consume without accept drops valid, data holds
    cyc(0, 5'd0, 5'd0, 5'd0, 12'h000, 0, 1, 0, 5'd0, 32'd0);
    cyc(0, 5'd0, 5'd0, 5'd0, 12'h000, 0, 1, 1, 5'd9, 32'h9999_9999);
    cyc(0, 5'd0, 5'd0, 5'd0, 12'h000, 0, 1, 1, 5'd10, 32'hAAAA_AAAA);

    // random traffic on a small register window
    for (int i = 0; i < 150; i++) begin
      cyc($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)), 12'($urandom), $urandom_range(0, 1) == 1,
          $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
          5'($urandom_range(0, 7)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_regfile.md
# decode_regfile

Decode-stage register file with scoreboard and output pipeline register. Consumes the fetch stage's decoded fields (rd, rs1, rs2, 12-bit imm) and reads both source operands. It tracks registers with an outstanding write-back and stalls fetch on a hazard. Accepted instructions are presented to the execute stage through a valid/ready pipeline register.

## Interface
- XLEN, 32, register/data width
- NREGS, 32, architectural register count (address width 5, fixed)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- id_valid  in  1  fetch presents an instruction this cycle
- id_ready  out  1  decode accepts the instruction this cycle
- rd  in  5  destination register
- rs1  in  5  source register 1
- rs2  in  5  source register 2
- imm  in  12  immediate, two's complement
- id_wen  in  1  instruction writes rd
- ex_valid  out  1  execute-stage register holds an instruction
- ex_ready  in  1  execute consumes the held instruction
- ex_rs1_data  out  XLEN  operand 1
- ex_rs2_data  out  XLEN  operand 2
- ex_imm  out  XLEN  sign-extended imm
- ex_rd  out  5  destination
- ex_wen  out  1  write-enable forwarded
- wb_en  in  1  write-back strobe
- wb_addr  in  5  write-back register
- wb_data  in  XLEN  write-back value

## Operation
- Storage: NREGS x XLEN. x0 reads 0 always. Writes to x0 are ignored.
- Write-back: wb_en && wb_addr!=0 writes wb_data at the clock edge and clears pending[wb_addr].
- Read path is combinational, with write-through bypass: if wb_en && wb_addr==rsX && rsX!=0, the operand is wb_data.
- Scoreboard: one pending bit per register. pending[0] is constantly 0.
- A source counts as busy when pending[rsX] is set and not cleared by a same-cycle write-back to rsX.
- hazard = (rs1 busy) | (rs2 busy) | (id_wen && rd!=0 && rd busy). The rd term stalls on WAW; one outstanding write per register.
- slot_free = !ex_valid | ex_ready.
- id_ready = !hazard & slot_free.
- accept = id_valid & id_ready.
- On accept: load ex_* fields. ex_imm = {{20{imm[11]}}, imm}. Set ex_valid=1. If id_wen && rd!=0, set pending[rd].
- Same-cycle set and clear of the same register: set wins, so the register stays pending.
- Consume without accept (ex_valid && ex_ready && !accept): ex_valid goes to 0. Data fields hold their values.
- With ex_valid && !ex_ready, all ex_* fields hold stable.
- id_ready depends on id_* inputs only through the hazard term; it does not depend on id_valid.

## Timing
- Reset (rst==0 at an edge): all registers 0, all pending bits 0, ex_valid=0, ex_wen=0, ex_rd=0, all ex_*_data and ex_imm=0.
- Reset takes priority over a simultaneous accept or write-back.
- During reset cycles id_ready is combinational and evaluates to 1.
- Latency: an instruction accepted at edge N appears on ex_* after edge N.
- Throughput: 1 instruction/cycle when hazard-free and ex_ready is held high.
- A write-back at edge N makes the new value visible combinationally in cycle N (bypass) and from storage after edge N.
- A stall released by a write-back in cycle N lets the instruction be accepted at edge N, with the bypassed data.

## Structure
- Shared package core_pkg: XLEN, NREGS, REG_AW=5, IMM_W=12, and a sign_extend_imm function.
- Sub-module regfile_array: storage, x0 hardwiring, synchronous write, two combinational read ports with write bypass.
- The scoreboard, handshake and pipeline register stay in decode_regfile.

## Test plan
- Reset: hold rst=0 for 2 cycles with id_valid=1 -> ex_valid=0, all outputs 0. Then a read of x1..x31 after release returns 0.
- Back-to-back, no hazard: wb writes x3=0x1234 earlier. Issue rs1=3, rs2=0, imm=0xFFF, ex_ready=1 -> next cycle ex_rs1_data=0x1234, ex_rs2_data=0, ex_imm=0xFFFFFFFF.
- RAW stall: issue rd=5 with id_wen=1, then rs1=5 -> id_ready=0 until wb_en with wb_addr=5, wb_data=0xABCD. Accepted in the write-back cycle -> ex_rs1_data=0xABCD.
- x0 handling: issue rd=0 with id_wen=1, then rs1=0 -> no stall. wb to x0 of 0xFFFF -> a read of x0 is still 0.
- Backpressure: ex_ready=0 for 3 cycles with ex_valid=1 -> id_ready=0 and ex_* stable. ex_ready=1 -> the new instruction is loaded the same edge.
- Set/clear collision: x7 is pending. Accept a new rd=7 writer in the same cycle as wb_addr=7 -> pending[7] stays 1, and a following reader of x7 stalls.
